// File: rtl/tvout_gen_if.sv
// rtl/tvout_gen_if.sv - framebuffer RAM read port between tvout_gen and video RAM
interface tvout_gen_if #(
    parameter int MEM_W  = 16,
    parameter int ADDR_W = 14
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]  mem_data;

    modport master (output mem_rd, output mem_addr, input mem_data);
    modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/tvout_gen.sv
// rtl/tvout_gen.sv - PAL-style progressive timing and monochrome pixel serialiser
// Optional white outline in the active region when TVOUT_BORDER_EN is defined.
module tvout_gen #(
    parameter int CLK_DIV      = 5,
    parameter int H_TOTAL      = 640,
    parameter int H_ACTIVE     = 512,
    parameter int H_SYNC_START = 533,
    parameter int H_SYNC_LEN   = 47,
    parameter int V_TOTAL      = 309,
    parameter int V_ACTIVE     = 287,
    parameter int V_SYNC_START = 288,
    parameter int V_SYNC_LINES = 2,
    parameter int V_SYNC_HALF  = 1,
    parameter int MEM_W        = 16,
    parameter int ADDR_W       = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    tvout_gen_if.master mem,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        vout,
    output logic        sync_
);
    localparam int DW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int XW    = $clog2(H_TOTAL + 1);
    localparam int YW    = $clog2(V_TOTAL + 1);
    localparam int MW_LG = (MEM_W > 2) ? $clog2(MEM_W) : 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] HT_M1    = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] HA_C     = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HA_M1    = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] HSS_C    = XW'(H_SYNC_START);
    localparam logic [XW-1:0] HSE_C    = XW'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [XW-1:0] HHALF_C  = XW'(H_TOTAL / 2);
    localparam logic [YW-1:0] VT_M1    = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] VA_C     = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VA_M1    = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] VSS_C    = YW'(V_SYNC_START);
    localparam logic [YW-1:0] VSE_C    = YW'(V_SYNC_START + V_SYNC_LINES);

    logic [DW-1:0]     div_q, div_d;
    logic [XW-1:0]     x_q, x_d, nx;
    logic [YW-1:0]     y_q, y_d, ny;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d, mem_addr_q, mem_addr_d, addr_use;
    logic [MEM_W-1:0]  shift_q, shift_d;
    logic              primed_q, primed_d;
    logic              mem_rd_q, mem_rd_d, frame_start_q, frame_start_d;
    logic              vout_q, vout_d, sync_q, sync_d;
    logic              tick, x_end, wrap, active, hsync, vsync, fetch, border;

    assign tick   = (div_q == '0);
    assign x_end  = (x_q == HT_M1);
    assign wrap   = x_end && (y_q == VT_M1);
    assign nx     = x_end ? '0 : x_q + 1'b1;
    assign ny     = x_end ? ((y_q == VT_M1) ? '0 : y_q + 1'b1) : y_q;
    assign active = (x_q < HA_C) && (y_q < VA_C);
    assign hsync  = (x_q >= HSS_C) && (x_q < HSE_C);
    assign vsync  = ((y_q >= VSS_C) && (y_q < VSE_C)) ||
                    ((V_SYNC_HALF != 0) && (y_q == VSE_C) && (x_q < HHALF_C));
    // After reset nothing is fetched until the end of the first frame, so frame 0 is blank.
    assign fetch  = (nx[MW_LG-1:0] == '0) && (nx < HA_C) && (ny < VA_C) && (primed_q || wrap);
`ifdef TVOUT_BORDER_EN
    assign border = active && ((x_q == '0) || (x_q == HA_M1) || (y_q == '0) || (y_q == VA_M1));
`else
    assign border = 1'b0;
`endif

    always_comb begin
        div_d         = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        x_d           = x_q;
        y_d           = y_q;
        addr_cnt_d    = addr_cnt_q;
        mem_addr_d    = mem_addr_q;
        addr_use      = wrap ? '0 : addr_cnt_q;
        shift_d       = shift_q;
        primed_d      = primed_q;
        mem_rd_d      = 1'b0;
        frame_start_d = 1'b0;
        vout_d        = vout_q;
        sync_d        = sync_q;
        if (tick) begin
            x_d           = nx;
            y_d           = ny;
            frame_start_d = (x_q == '0) && (y_q == '0);
            sync_d        = ~(hsync | vsync);
            if (active) begin
                if (x_q[MW_LG-1:0] == '0) begin
                    shift_d = primed_q ? mem.mem_data : '0;
                end else begin
                    shift_d = {shift_q[MEM_W-2:0], 1'b0};
                end
                vout_d = shift_d[MEM_W-1] | border;
            end else begin
                vout_d = 1'b0;
            end
            if (fetch) begin
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_use;
                addr_cnt_d = addr_use + 1'b1;
            end
            if (wrap) begin
                primed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            addr_cnt_q    <= '0;
            mem_addr_q    <= '0;
            shift_q       <= '0;
            primed_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            frame_start_q <= 1'b0;
            vout_q        <= 1'b0;
            sync_q        <= 1'b1;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            addr_cnt_q    <= addr_cnt_d;
            mem_addr_q    <= mem_addr_d;
            shift_q       <= shift_d;
            primed_q      <= primed_d;
            mem_rd_q      <= mem_rd_d;
            frame_start_q <= frame_start_d;
            vout_q        <= vout_d;
            sync_q        <= sync_d;
        end
    end

    // Gated so the tick reads 0 while held in reset and 1 on the first edge after release.
    assign pix_tick     = tick & rst_n;
    assign mem.mem_rd   = mem_rd_q;
    assign mem.mem_addr = mem_addr_q;
    assign frame_start  = frame_start_q;
    assign vout         = vout_q;
    assign sync_        = sync_q;
endmodule
